// File: rtl/reg_access_ctrl.sv
// Host/debug access controller for the eight LC-3 general registers.
// Borrows the register-file ports to write, read or dump the registers.
module reg_access_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [2:0]  resp_idx,
  output logic        resp_last,
  input  logic        cpu_idle,
  output logic        port_active,
  output logic        LDREG,
  output logic [2:0]  dr,
  output logic [15:0] bus_out,
  output logic [2:0]  sr1,
  input  logic [15:0] sr1out,
  output logic [2:0]  sr2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_hs;
  logic [2:0]  r_idx;
  logic        r_dump;
  logic [2:0]  r_dr;
  logic [15:0] r_bus;
  logic [2:0]  r_sr1;
  logic [15:0] r_rdata;
  logic [2:0]  r_ridx;
  logic        r_rlast;

  assign req_ready   = (r_state == S_IDLE) && cpu_idle;
  assign w_accept    = req_valid && req_ready;
  assign w_hs        = (r_state == S_RESP) && resp_ready;
  assign resp_valid  = (r_state == S_RESP);
  assign port_active = (r_state != S_IDLE);
  assign LDREG       = (r_state == S_WRITE);
  assign dr          = r_dr;
  assign bus_out     = r_bus;
  assign sr1         = r_sr1;
  assign sr2         = 3'b000;
  assign resp_data   = r_rdata;
  assign resp_idx    = r_ridx;
  assign resp_last   = r_rlast;

  // Next-state selection; a handshake on the last word returns to IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (req_cmd)
            CMD_WR:   w_next = S_WRITE;
            CMD_RD:   w_next = S_READ;
            CMD_DUMP: w_next = S_READ;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_WRITE: w_next = S_IDLE;
      S_READ:  w_next = S_RESP;
      S_RESP: begin
        if (w_hs) w_next = r_rlast ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Port drives, dump index and the held response word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx   <= 3'd0;
      r_dump  <= 1'b0;
      r_dr    <= 3'd0;
      r_bus   <= 16'd0;
      r_sr1   <= 3'd0;
      r_rdata <= 16'd0;
      r_ridx  <= 3'd0;
      r_rlast <= 1'b0;
    end else begin
      if (w_accept) begin
        case (req_cmd)
          CMD_WR: begin
            r_dr  <= req_addr;
            r_bus <= req_data;
          end
          CMD_RD: begin
            r_sr1  <= req_addr;
            r_dump <= 1'b0;
          end
          CMD_DUMP: begin
            r_sr1  <= 3'd0;
            r_idx  <= 3'd0;
            r_dump <= 1'b1;
          end
          default: ;
        endcase
      end
      if (r_state == S_READ) begin
        r_rdata <= sr1out;
        r_ridx  <= r_sr1;
        r_rlast <= !r_dump || (r_idx == 3'd7);
      end
      if (w_hs && !r_rlast) begin
        r_idx <= r_idx + 3'd1;
        r_sr1 <= r_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_reg_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [2:0]  req_addr;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_idx;
  logic        resp_last;
  logic        cpu_idle;
  logic        port_active;
  logic        LDREG;
  logic [2:0]  dr;
  logic [15:0] bus_out;
  logic [2:0]  sr1;
  logic [15:0] sr1out;
  logic [2:0]  sr2;

  logic [15:0] rf [8];

  int n_chk  = 0;
  int n_pass = 0;
  int n_rv   = 0;

  always #5 Clk = ~Clk;

  reg_access_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_idx(resp_idx),
    .resp_last(resp_last),
    .cpu_idle(cpu_idle), .port_active(port_active),
    .LDREG(LDREG), .dr(dr), .bus_out(bus_out),
    .sr1(sr1), .sr1out(sr1out), .sr2(sr2)
  );

  always @(posedge Clk) if (LDREG) rf[dr] <= bus_out;
  assign sr1out = rf[sr1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Present one request in an idle cycle; returns inside the next cycle.
  task automatic send(input logic [1:0] c,
                      input logic [2:0] a,
                      input logic [15:0] d);
    @(posedge Clk); #1;
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_data  = d;
    @(negedge Clk);
    chk("accept_rdy", req_ready, 1);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    req_cmd   = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    Reset = 1'b1; req_valid = 0; req_cmd = 0;
    req_addr = 0; req_data = 0;
    resp_ready = 0; cpu_idle = 1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_pa", port_active, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_ld", LDREG, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_rdy", req_ready, 1);
    chk("sr2", sr2, 0);

    // Write 0xBEEF to R3.
    send(2'b01, 3'd3, 16'hBEEF);
    @(negedge Clk);
    chk("wr_ld", LDREG, 1);
    chk("wr_dr", dr, 3);
    chk("wr_bus", bus_out, 16'hBEEF);
    chk("wr_rdy", req_ready, 0);
    chk("wr_rv", resp_valid, 0);
    @(negedge Clk);
    chk("wr_ld_off", LDREG, 0);
    chk("wr_dr_hold", dr, 3);
    chk("wr_pa_off", port_active, 0);
    chk("wr_rf3", rf[3], 16'hBEEF);

    // Read R3 with resp_ready held low for 3 cycles.
    send(2'b10, 3'd3, 16'h0);
    @(negedge Clk);
    chk("rd_rv_early", resp_valid, 0);
    chk("rd_sr1", sr1, 3);
    chk("rd_pa", port_active, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("rd_rv", resp_valid, 1);
      chk("rd_data", resp_data, 16'hBEEF);
      chk("rd_idx", resp_idx, 3);
      chk("rd_last", resp_last, 1);
    end
    @(posedge Clk); #1 resp_ready = 1'b1;
    @(negedge Clk);
    chk("rd_rv_hs", resp_valid, 1);
    @(posedge Clk); #1 resp_ready = 1'b0;
    @(negedge Clk);
    chk("rd_done_rv", resp_valid, 0);
    chk("rd_done_pa", port_active, 0);

    // Command 00 is consumed with no effect.
    send(2'b00, 3'd1, 16'h5555);
    @(negedge Clk);
    chk("nop_pa", port_active, 0);
    chk("nop_ld", LDREG, 0);

    // Preload Rn = 0x1000+n, then dump with resp_ready high.
    for (int n = 0; n < 8; n++)
      send(2'b01, 3'(n), 16'h1000 + 16'(n));
    resp_ready = 1'b1;
    send(2'b11, 3'd5, 16'h0);
    for (int w = 0; w < 8; w++) begin
      @(negedge Clk);
      chk("dmp_rd_rv", resp_valid, 0);
      chk("dmp_sr1", sr1, w);
      @(negedge Clk);
      chk("dmp_rv", resp_valid, 1);
      chk("dmp_data", resp_data, 16'h1000 + 16'(w));
      chk("dmp_idx", resp_idx, w);
      chk("dmp_last", resp_last, (w == 7));
    end
    @(negedge Clk);
    chk("dmp_end_pa", port_active, 0);
    chk("dmp_end_rv", resp_valid, 0);
    chk("dmp_end_rdy", req_ready, 1);

    // cpu_idle low blocks accepts.
    resp_ready = 1'b0;
    @(posedge Clk); #1;
    cpu_idle  = 1'b0;
    req_valid = 1'b1;
    req_cmd   = 2'b01;
    req_addr  = 3'd2;
    req_data  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("busy_rdy", req_ready, 0);
      chk("busy_ld", LDREG, 0);
      @(posedge Clk); #1;
    end
    cpu_idle = 1'b1;
    @(negedge Clk);
    chk("idle_rdy", req_ready, 1);
    @(posedge Clk); #1 req_valid = 1'b0;
    @(negedge Clk);
    chk("idle_ld", LDREG, 1);
    chk("idle_dr", dr, 2);
    chk("idle_bus", bus_out, 16'h1234);

    // cpu_idle dropping mid-read does not abort.
    send(2'b10, 3'd2, 16'h0);
    cpu_idle = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_rv", resp_valid, 1);
    chk("mid_data", resp_data, 16'h1234);
    chk("mid_rdy", req_ready, 0);
    @(posedge Clk); #1 resp_ready = 1'b1;
    @(posedge Clk); #1 resp_ready = 1'b0;
    cpu_idle = 1'b1;
    @(negedge Clk);
    chk("mid_done_pa", port_active, 0);

    // Reset during dump while reading index 4.
    resp_ready = 1'b1;
    send(2'b11, 3'd0, 16'h0);
    for (int w = 0; w < 4; w++) repeat (2) @(negedge Clk);
    @(posedge Clk); #1;
    chk("pre_rst_sr1", sr1, 4);
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("arst_pa", port_active, 0);
    chk("arst_rv", resp_valid, 0);
    chk("arst_ld", LDREG, 0);
    chk("arst_dr", dr, 0);
    chk("arst_bus", bus_out, 0);
    chk("arst_sr1", sr1, 0);
    chk("arst_data", resp_data, 0);
    chk("arst_idx", resp_idx, 0);
    chk("arst_last", resp_last, 0);
    n_rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (resp_valid) n_rv++;
    end
    chk("arst_no_rv", n_rv, 0);

    // Write R7 then back-to-back read R7.
    send(2'b01, 3'd7, 16'h7FFF);
    send(2'b10, 3'd7, 16'h0);
    @(negedge Clk);
    @(negedge Clk);
    chk("b2b_rv", resp_valid, 1);
    chk("b2b_data", resp_data, 16'h7FFF);
    chk("b2b_idx", resp_idx, 7);
    @(negedge Clk);
    chk("b2b_done", port_active, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Purpose: host/debug initiator that writes, reads and dumps the eight 16-bit LC-3 general registers by driving the register file's load/select ports.

Interface
REQ-001 SHALL have: Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 SHALL have: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  input  1  host request present.
REQ-004 SHALL have: req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-005 SHALL have: req_cmd  input  2  00 none, 01 write, 10 read, 11 dump.
REQ-006 SHALL have: req_addr  input  3  target register index (write/read; ignored for dump).
REQ-007 SHALL have: req_data  input  16  write data.
REQ-008 SHALL have: resp_valid  output  1  response word present.
REQ-009 SHALL have: resp_ready  input  1  host consumes response when high with resp_valid.
REQ-010 SHALL have: resp_data  output  16  read value; resp_idx  output  3  its register index; resp_last  output  1  final word of a read/dump.
REQ-011 SHALL have: cpu_idle  input  1  datapath may be borrowed; port_active  output  1  high whenever state is not IDLE (steers register-file port mux).
REQ-012 SHALL have: LDREG  output  1, dr  output  3, bus_out  output  16  register-file write port.
REQ-013 SHALL have: sr1  output  3  register-file read select; sr1out  input  16  combinational read data; sr2  output  3, driven constant 3'b000.

Function
REQ-014 States SHALL be IDLE, WRITE, READ, RESP only.
REQ-015 req_ready SHALL equal (state==IDLE) && cpu_idle, combinationally; no other source.
REQ-016 Accept with cmd 00 SHALL be consumed with no effect, state stays IDLE.
REQ-017 Write accept: next cycle state WRITE, LDREG=1, dr=req_addr, bus_out=req_data (registered), for exactly one cycle; then IDLE; no response generated.
REQ-018 LDREG SHALL be 1 only in WRITE; dr and bus_out SHALL hold last value otherwise.
REQ-019 Read accept: next cycle READ with sr1=req_addr; at end of that cycle resp_data<=sr1out, resp_idx<=sr1, resp_last<=1; then RESP.
REQ-020 Dump accept: internal index=0, READ with sr1=index; resp_last<=1 only when index==7.
REQ-021 RESP: resp_valid=1, resp_data/resp_idx/resp_last stable until resp_ready; on handshake, if resp_last then IDLE else index+1 and READ.
REQ-022 Latency: write effect 1 cycle after accept; first resp_valid 2 cycles after accept; dump = 2 cycles per word minimum, 16 cycles for 8 words with resp_ready held high.
REQ-023 Index SHALL never wrap: dump terminates after index 7.
REQ-024 cpu_idle falling mid-operation SHALL NOT abort; operation completes, new accepts blocked.
REQ-025 resp_valid SHALL be 0 in every state except RESP.
REQ-026 Write followed immediately by read of same register SHALL return the new value (write commits before READ cycle).

Reset
REQ-027 Reset SHALL force state IDLE, index 0, LDREG 0, dr 0, bus_out 0, sr1 0, resp_valid 0, resp_data 0, resp_idx 0, resp_last 0, port_active 0.
REQ-028 Reset mid-operation SHALL abort immediately: no LDREG pulse and no further responses after the reset cycle.

Verification
REQ-029 Reset; cpu_idle=1; write 0xBEEF to R3 -> cycle after accept LDREG=1, dr=3, bus_out=0xBEEF for one cycle; req_ready low that cycle.
REQ-030 Read R3 with behavioural regfile, resp_ready low 3 cycles -> resp_valid 2 cycles after accept, resp_data=0xBEEF, resp_idx=3, resp_last=1, held stable 3 cycles.
REQ-031 Preload Rn=0x1000+n, dump, resp_ready=1 -> 8 words 0x1000..0x1007, idx 0..7, resp_last only on idx 7, done 16 cycles after accept.
REQ-032 cpu_idle=0 with req_valid=1 for 5 cycles -> req_ready 0, no LDREG; cpu_idle=1 -> accepted same cycle.
REQ-033 Reset during dump at idx 4 -> next cycle all outputs at reset values, state IDLE, no further resp_valid.
REQ-034 Write 0x7FFF to R7 then back-to-back read R7 -> resp_data=0x7FFF.
